// File: rtl/extmem_pkg.sv
// Shared constants, queue entry type and address check
// for the external-memory responder.
package extmem_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 16;
   localparam int MEM_AW   = 12;
   localparam int WQ_DEPTH = 4;
   localparam int PTR_W    = $clog2(WQ_DEPTH);
   localparam int LVL_W    = PTR_W + 1;

   typedef struct packed {
      logic [MEM_AW-1:0] addr;
      logic [DATA_W-1:0] data;
   } wq_entry_t;

   function automatic logic in_range(
      input logic [ADDR_W-1:0] a
   );
      return a[ADDR_W-1:MEM_AW] == '0;
   endfunction
endpackage

// File: rtl/extmem_if.sv
// Controller-to-responder request bus: one read
// port and one posted write port, no backpressure.
interface extmem_if;
   import extmem_pkg::*;

   logic              re;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output re, rd_addr, we, wr_addr, wr_data,
      input  rd_data
   );

   modport slave (
      input  re, rd_addr, we, wr_addr, wr_data,
      output rd_data
   );
endinterface

// File: rtl/extmem_wq.sv
// Posted-write FIFO with a newest-match address
// lookup used for read-after-write forwarding.
module extmem_wq
   import extmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  wq_entry_t         push_ent,
   input  logic              pop,
   output wq_entry_t         head,
   input  logic [MEM_AW-1:0] look_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   output logic [LVL_W-1:0]  level,
   output logic              full,
   output logic              empty
);
   wq_entry_t        slots [WQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] idx;

   // entry storage; validity comes from the pointers only
   always_ff @(posedge clk) begin
      if (push) slots[wr_ptr] <= push_ent;
   end

   // pointers wrap naturally, level tracks occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (!push && pop) level <= level - 1'b1;
      end
   end

   // walk oldest to newest so the newest match wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (LVL_W'(i) < level &&
             slots[idx].addr == look_addr) begin
            hit      = 1'b1;
            hit_data = slots[idx].data;
         end
      end
   end

   assign head  = slots[rd_ptr];
   assign full  = level == LVL_W'(WQ_DEPTH);
   assign empty = level == '0;
endmodule

// File: rtl/extmem_responder.sv
// Single-port SRAM responder: reads own the port,
// posted writes drain in read-free cycles.
module extmem_responder
   import extmem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   extmem_if.slave          bus,
   input  logic             clr_err,
   output logic [LVL_W-1:0] wq_level,
   output logic             idle,
   output logic             wq_overflow,
   output logic             oor_err
);
   logic [DATA_W-1:0] mem [2**MEM_AW];
   logic [DATA_W-1:0] sram_q;
   logic [DATA_W-1:0] fwd_q;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] hit_data;
   logic              rd_pend;
   logic              use_fwd;
   logic              hit;
   logic              rd_ok;
   logic              wr_ok;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              ovf_ev;
   logic              oor_ev;
   wq_entry_t         head;
   wq_entry_t         push_ent;

   assign rd_ok  = in_range(bus.rd_addr);
   assign wr_ok  = in_range(bus.wr_addr);
   assign pop    = !bus.re && !empty;
   assign push   = bus.we && wr_ok && (!full || pop);
   assign ovf_ev = bus.we && wr_ok && full && !pop;
   assign oor_ev = (bus.re && !rd_ok) ||
                   (bus.we && !wr_ok);

   assign push_ent.addr = bus.wr_addr[MEM_AW-1:0];
   assign push_ent.data = bus.wr_data;

   extmem_wq u_wq (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_ent  (push_ent),
      .pop       (pop),
      .head      (head),
      .look_addr (bus.rd_addr[MEM_AW-1:0]),
      .hit       (hit),
      .hit_data  (hit_data),
      .level     (wq_level),
      .full      (full),
      .empty     (empty)
   );

   // single SRAM port: a read wins, else drain the head
   always_ff @(posedge clk) begin
      if (bus.re)
         sram_q <= mem[bus.rd_addr[MEM_AW-1:0]];
      else if (pop)
         mem[head.addr] <= head.data;
   end

   // capture forward source, then pick it or SRAM data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend <= 1'b0;
         use_fwd <= 1'b0;
         fwd_q   <= '0;
         rd_q    <= '0;
      end else begin
         rd_pend <= bus.re;
         if (bus.re) begin
            use_fwd <= !rd_ok || hit;
            fwd_q   <= rd_ok ? hit_data : '0;
         end
         if (rd_pend)
            rd_q <= use_fwd ? fwd_q : sram_q;
      end
   end

   // sticky flags; a new event beats a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wq_overflow <= 1'b0;
         oor_err     <= 1'b0;
      end else begin
         if (ovf_ev)       wq_overflow <= 1'b1;
         else if (clr_err) wq_overflow <= 1'b0;
         if (oor_ev)       oor_err <= 1'b1;
         else if (clr_err) oor_err <= 1'b0;
      end
   end

   assign bus.rd_data = rd_q;
   assign idle        = empty;
endmodule

// File: tb/tb_extmem_responder.sv
// Directed test of extmem_responder against a
// queue-based behavioural model checked every cycle.
module tb_extmem_responder;
   logic       clk = 1'b0;
   logic       rst;
   logic       clr_err;
   logic [2:0] wq_level;
   logic       idle;
   logic       wq_overflow;
   logic       oor_err;

   extmem_if bus ();

   extmem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .clr_err     (clr_err),
      .wq_level    (wq_level),
      .idle        (idle),
      .wq_overflow (wq_overflow),
      .oor_err     (oor_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string n, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  n, act, exp, $time);
      end
   endtask

   // behavioural model: posted writes as a plain queue
   typedef struct {
      int          a;
      logic [15:0] d;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] smem [4096];
   bit          kn   [4096];
   logic [15:0] exp_rd = '0;
   bit          exp_k  = 1'b1;
   bit          pv     = 1'b0;
   logic [15:0] pd     = '0;
   bit          pk     = 1'b0;
   bit          m_ovf  = 1'b0;
   bit          m_oor  = 1'b0;
   bit          o_ev;
   bit          v_ev;
   bit          found;
   int          ai;
   ent_t        ne;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         exp_rd = '0;
         exp_k  = 1'b1;
         pv     = 1'b0;
         m_ovf  = 1'b0;
         m_oor  = 1'b0;
      end else begin
         o_ev = 1'b0;
         v_ev = 1'b0;
         if (pv) begin
            exp_rd = pd;
            exp_k  = pk;
         end
         pv = bus.re;
         if (bus.re) begin
            if (bus.rd_addr >= 16'h1000) begin
               pd   = '0;
               pk   = 1'b1;
               o_ev = 1'b1;
            end else begin
               ai    = int'(bus.rd_addr);
               found = 1'b0;
               foreach (mq[i])
                  if (mq[i].a == ai) begin
                     pd    = mq[i].d;
                     found = 1'b1;
                  end
               if (found) pk = 1'b1;
               else begin
                  pd = smem[ai];
                  pk = kn[ai];
               end
            end
         end else if (mq.size() > 0) begin
            smem[mq[0].a] = mq[0].d;
            kn[mq[0].a]   = 1'b1;
            void'(mq.pop_front());
         end
         if (bus.we) begin
            if (bus.wr_addr >= 16'h1000) o_ev = 1'b1;
            else if (mq.size() < 4) begin
               ne.a = int'(bus.wr_addr);
               ne.d = bus.wr_data;
               mq.push_back(ne);
            end else v_ev = 1'b1;
         end
         if (v_ev)         m_ovf = 1'b1;
         else if (clr_err) m_ovf = 1'b0;
         if (o_ev)         m_oor = 1'b1;
         else if (clr_err) m_oor = 1'b0;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (exp_k) chk("rd_data", bus.rd_data, exp_rd);
         chk("wq_level", wq_level, mq.size());
         chk("idle", idle, mq.size() == 0);
         chk("wq_overflow", wq_overflow, m_ovf);
         chk("oor_err", oor_err, m_oor);
      end
   end

   task automatic step(bit r, logic [15:0] ra, bit w,
                       logic [15:0] wa, logic [15:0] wd,
                       bit c);
      bus.re      = r;
      bus.rd_addr = ra;
      bus.we      = w;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      clr_err     = c;
      @(posedge clk);
      #2;
   endtask

   task automatic nop(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(logic [15:0] a, logic [15:0] d);
      step(0, 0, 1, a, d, 0);
   endtask

   task automatic rd(logic [15:0] a);
      step(1, a, 0, 0, 0, 0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.re      = 1'b0;
      bus.rd_addr = '0;
      bus.we      = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      clr_err     = 1'b0;
      #1;
      chk("reset rd_data", bus.rd_data, 0);
      chk("reset idle", idle, 1);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;

      // write then read with an empty queue
      wr(16'h0010, 16'hBEEF);
      nop(1);
      chk("t1 idle", idle, 1);
      rd(16'h0010);
      nop(1);
      chk("t1 rd", bus.rd_data, 16'hBEEF);

      // forwarding while re is held high
      wr(16'h0020, 16'h1111);
      nop(2);
      step(1, 16'h0020, 1, 16'h0020, 16'h2222, 0);
      step(1, 16'h0020, 1, 16'h0020, 16'h3333, 0);
      rd(16'h0020);
      rd(16'h0020);
      chk("t2 fwd", bus.rd_data, 16'h3333);
      chk("t2 level", wq_level, 2);
      nop(3);

      // same-cycle read and write is read-before-write
      wr(16'h0030, 16'h0A0A);
      nop(1);
      step(1, 16'h0030, 1, 16'h0030, 16'h5555, 0);
      nop(1);
      chk("t3 old", bus.rd_data, 16'h0A0A);
      rd(16'h0030);
      nop(1);
      chk("t3 new", bus.rd_data, 16'h5555);

      // overflow with re held high
      wr(16'h0104, 16'hAAAA);
      nop(1);
      for (int i = 0; i < 5; i++)
         step(1, 16'h0010, 1, 16'h0100 + 16'(i),
              16'h0100 + 16'(i), 0);
      chk("t4 level", wq_level, 4);
      chk("t4 ovf", wq_overflow, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t4 clr", wq_overflow, 0);
      nop(4);
      rd(16'h0104);
      rd(16'h0103);
      chk("t4 dropped", bus.rd_data, 16'hAAAA);
      nop(1);
      chk("t4 kept", bus.rd_data, 16'h0103);

      // out-of-range read and write
      rd(16'h1000);
      nop(1);
      chk("t5 rd0", bus.rd_data, 0);
      chk("t5 oor", oor_err, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("t5 clr", oor_err, 0);
      wr(16'h1000, 16'h7777);
      chk("t5 level", wq_level, 0);
      chk("t5 oor wr", oor_err, 1);
      step(0, 0, 0, 0, 0, 1);

      // reset while writes are still queued
      wr(16'h0050, 16'h5050);
      nop(1);
      for (int i = 0; i < 3; i++)
         step(1, 16'h0050, 1, 16'h0200 + 16'(i),
              16'h0001, 0);
      chk("t6 level pre", wq_level, 3);
      chk("t6 rd pre", bus.rd_data, 16'h5050);
      rst = 1'b1;
      #1;
      chk("t6 level", wq_level, 0);
      chk("t6 idle", idle, 1);
      chk("t6 rd", bus.rd_data, 0);
      bus.re = 1'b0;
      bus.we = 1'b0;
      #1;
      rst = 1'b0;
      rd(16'h0050);
      nop(1);
      chk("t6 survive", bus.rd_data, 16'h5050);
      nop(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/extmem_responder.md
# extmem_responder

Responder end of the accelerator's external-memory interface: it serves the controller's single-cycle read and write requests (`re`/`rd_addr`/`rd_data`, `we`/`wr_addr`/`wr_data`) from a single-port on-chip backing SRAM. Writes are posted into a small write queue and drained to the SRAM in cycles with no read. Reads get a fixed 1-cycle latency, with read-after-write forwarding from the queue. The block sits beside the controller in the top level and replaces the behavioural external-memory model used in simulation.

## Interface
- `DATA_W`, 16, data word width.
- `ADDR_W`, 16, request address width.
- `MEM_AW`, 12, backing SRAM address width (2^MEM_AW words).
- `WQ_DEPTH`, 4, write-queue entries (power of two, ≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `re`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  read data, registered.
- `we`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `clr_err`  in  1  clears the sticky error flags.
- `wq_level`  out  $clog2(WQ_DEPTH)+1  current queue occupancy.
- `idle`  out  1  high when the queue is empty.
- `wq_overflow`  out  1  sticky: a write was dropped.
- `oor_err`  out  1  sticky: an access had an address ≥ 2^MEM_AW.

## Operation
- **No backpressure.** The requester never stalls, so every request is handled or flagged in the cycle it is issued.
- **Read.**
  - `re` is sampled at edge N. `rd_data` is valid after edge N+1 and holds until the next read completes.
  - Data source priority:
    1. Newest queue entry whose address equals `rd_addr`, evaluated at the same edge.
    2. Otherwise, the SRAM contents.
  - A write issued in the same cycle as a read is not forwarded. The read returns the prior value (read-before-write).
  - The forwarded value is captured at edge N. A 1-bit select register chooses between the captured value and the SRAM output at N+1.
- **Write.**
  - `we` pushes {`wr_addr`[MEM_AW-1:0], `wr_data`} at the tail of the queue.
  - When the queue is full and no pop occurs that cycle, the write is dropped and `wq_overflow` is set.
  - When the queue is full and a pop occurs that cycle, the push is accepted.
- **Drain arbiter.**
  - In each cycle with `re`=0 and the queue non-empty, the head entry is written to the SRAM and popped.
  - `re`=1 always owns the SRAM port, and no pop occurs that cycle.
- **Simultaneous push and pop.** Occupancy is unchanged. The pointers wrap modulo WQ_DEPTH.
- **Out-of-range addresses** (bits above MEM_AW nonzero) set `oor_err`:
  - A read returns 0 and is not forwarded.
  - A write is not enqueued.
- **Error flags.** `clr_err` clears both flags. If a new error event occurs in the same cycle, the event wins and the flag is set.
- **Reset.**
  - Outputs: `rd_data`=0, `wq_level`=0, `idle`=1, both flags 0.
  - The queue is flushed, so posted writes are lost.
  - SRAM contents are not cleared.

## Timing
- Read latency is exactly 1 cycle, with back-to-back reads every cycle. This matches the controller's pattern of writing the buffer one cycle after `re`.
- Write commit latency:
  - Best case: enqueued at edge N, committed to the SRAM at edge N+1.
  - Worst case: deferred for as long as `re` stays high.
- Writes are committed in FIFO order. Forwarding keeps reads coherent at any queue level.
- `idle` and `wq_level` are registered and update at the edge after a push or pop.

## Structure
- Package `extmem_pkg` holds:
  - Constants: `DATA_W`, `ADDR_W`, `MEM_AW`, `WQ_DEPTH`.
  - Typedef `wq_entry_t` as a packed struct {addr, data}.
  - An address-range check function.
- Sub-module `extmem_wq`:
  - WQ_DEPTH-entry FIFO with push and pop.
  - Parallel address compare returning the newest-match hit and its data.
  - Occupancy counter.
- The top level contains the single-port SRAM array (synchronous read), the arbiter, the forward-select register and the error flags.

## Test plan
- **Write then read, no queue occupancy at read time:**
  - Stimulus: `we` to addr 0x010 with 0xBEEF; two cycles later, `re` 0x010.
  - Expected: `rd_data`=0xBEEF one cycle after `re`; `idle`=1 at the time of the read.
- **Forwarding from the queue:**
  - Stimulus: hold `re` high continuously on addr 0x020 (pre-loaded 0x1111). Issue `we` to 0x020 with 0x2222, then `we` to 0x020 with 0x3333.
  - Expected: the read following the second write returns 0x3333 (newest entry); `wq_level`=2.
- **Same-cycle read and write:**
  - Stimulus: `re` and `we` both on 0x030 (old value 0x0A0A, new value 0x5555).
  - Expected: `rd_data`=0x0A0A; the next read of 0x030 returns 0x5555.
- **Overflow:**
  - Stimulus: keep `re`=1 and issue 5 writes with WQ_DEPTH=4.
  - Expected: `wq_level`=4 and `wq_overflow`=1; the 5th write is absent after draining. `clr_err` then clears the flag.
- **Out-of-range access:**
  - Stimulus: `re` on 0x1000 with MEM_AW=12.
  - Expected: `rd_data`=0 and `oor_err`=1.
  - Stimulus: `we` on 0x1000.
  - Expected: not enqueued; `wq_level` unchanged.
- **Reset mid-drain:**
  - Stimulus: 3 entries queued with `re` held high; assert `rst`.
  - Expected: `wq_level`=0, `idle`=1, `rd_data`=0; previously committed SRAM words survive.
